rc_c2f_buffer: RTL and testbench
================================

# rc_c2f_buffer

Core-to-fabric (C2F) request buffer of the ring controller. It accepts memory/CR requests from the core that target a remote agent, holds them in `C2F_ENTRIESNUM` tracked entries, and presents them in arrival order to the ring-output arbiter as the `C2F_REQUEST` source. It matches returning `RD_RSP` and broadcast-return packets from the ring input against entries, and hands read data back to the requesting thread.

## Interface
Parameters (all from `lotr_pkg`):
- `C2F_ENTRIESNUM`, 4: number of entries.
- `C2F_MSB` / `C2F_ENC_MSB`, 3 / 1: entry-vector MSB and entry-id MSB.

Ports:
- `QClk` in 1: clock.
- `RstQnt` in 1: reset, asynchronous, active-low.
- `CoreReqValid` in 1: core request strobe.
- `CoreReqOpcode` in `t_opcode` (2): `RD`, `WR` or `WR_BCAST`. `RD_RSP` is illegal here.
- `CoreReqAddress` in 32: full address (core id [31:24], region [23:22]).
- `CoreReqData` in 32: write data.
- `CoreReqThread` in 2: requesting thread.
- `C2fFull` out 1: no `FREE` entry this cycle.
- `C2fReqValid` out 1: head request is available to the arbiter.
- `C2fReqOpcode` out 2, `C2fReqAddress` out 32, `C2fReqData` out 32, `C2fReqId` out `C2F_ENC_MSB+1`: head request fields.
- `C2fReqGnt` in 1: the arbiter selected `C2F_REQUEST` this cycle.
- `RingRspValid` in 1, `RingRspId` in 2, `RingRspData` in 32: `RD_RSP` addressed to this agent.
- `RingBcastRetValid` in 1, `RingBcastRetId` in 2: own `WR_BCAST` completed the ring.
- `CoreRspValid` out 1, `CoreRspThread` out 2, `CoreRspData` out 32: read completion to the core.
- `C2fError` out 1: sticky protocol-error flag.

## Operation
- Each entry holds `t_state`, opcode, address, data and thread.
- An entry id FIFO (depth `C2F_ENTRIESNUM`) records the issue order.
- **Allocate:** when `CoreReqValid` is high and `C2fFull` is low, the lowest-index `FREE` entry is written. It moves to `READ` (`RD`), `WRITE` (`WR`) or `WRITE_BCAST` (`WR_BCAST`), and its id is pushed into the FIFO.
- **Issue:** `C2fReqValid` is high when the FIFO is non-empty. The `C2fReq*` fields come from the head entry and `C2fReqId` is the head id. On `C2fReqGnt` with `C2fReqValid` high, the FIFO pops and the head entry transitions:
  - `WRITE` → `FREE`.
  - `READ` → `READ_PRGRS`.
  - `WRITE_BCAST` → `WRITE_BCAST_PRGRS`.
- **Read return:** when `RingRspValid` is high and entry `RingRspId` is in `READ_PRGRS`, that entry goes to `READ_RDY` and its data field is overwritten with `RingRspData`.
- **Bcast return:** when `RingBcastRetValid` is high and the entry is in `WRITE_BCAST_PRGRS`, the entry goes to `FREE`.
- **Deliver:** `CoreRspValid` is high when any entry is in `READ_RDY`. The lowest-index such entry drives `CoreRspThread`/`CoreRspData` and goes to `FREE` at the clock edge. The core always accepts.
- **Errors (set `C2fError`, cleared only by reset; entry state unchanged, request dropped):**
  - Request while full.
  - `RD_RSP` opcode on the core side.
  - Return for an entry not in the expected `*_PRGRS` state.
- The `ERROR` state is never entered.

## Timing
- **Reset values:** all entries `FREE`, FIFO empty, every output 0 (`C2fFull` 0).
- Outputs are combinational from registered state. Every state change takes effect at the next `QClk` rising edge.
- **Latency:**
  - Allocate at cycle N → `C2fReqValid` at N+1 (if FIFO was empty).
  - Read response at N → `CoreRspValid` at N+1.
- **Freed-entry reuse:** an entry freed at edge N is allocatable from cycle N+1 only. Allocation in the same cycle as a free uses pre-edge state.
- **Simultaneous events:**
  - Grant, allocate, response, bcast return and deliver may all occur in one cycle on different entries; all apply.
  - FIFO push and pop in the same cycle keep its count.
- **Wrap-around:** FIFO pointers wrap mod `C2F_ENTRIESNUM`. The FIFO cannot overflow because entries are ≤ depth.
- **Async reset mid-operation:** discards all entries, including in-flight reads. Late ring returns then flag `C2fError`.

## Structure
- `lotr_pkg` supplies `t_opcode`, `t_state` and the `C2F_*` parameters.
- Add `C2F_ID_W = C2F_ENC_MSB+1` to the package.
- Sub-module `rc_c2f_id_fifo`: parameterized-depth FIFO of entry ids, with push/pop/empty and async active-low reset.

## Test plan
- **Basic read:** `RD` to addr 0x0240_0010 thread 2 → `C2fReqValid`, id 0 next cycle. Grant → entry 0 `READ_PRGRS`. `RingRspId`=0 with data 0xDEADBEEF → next cycle `CoreRspValid`, thread 2, data 0xDEADBEEF, then entry 0 `FREE`.
- **Fill to full:** four back-to-back `WR` with no grant → `C2fFull`=1. Fifth request → `C2fError`=1 and is dropped. A grant frees id 0 → `C2fFull`=0 next cycle.
- **Issue ordering:** allocate entries 0,1,2, free entry 0, allocate again (gets entry 0) → grant order 1,2,0.
- **Broadcast:** `WR_BCAST` granted → `WRITE_BCAST_PRGRS`, stays held. `RingBcastRetValid` id 0 → `FREE`.
- **Simultaneous events:** in the same cycle, a grant of the head `WR`, a new `RD` allocation and a `RingRspValid` for another entry → all three state updates occur.
- **Reset and stray return:** async reset asserted mid-`READ_PRGRS` → all outputs 0 immediately. A stray `RingRspValid` after reset → `C2fError`=1.

Source files
------------

// File: rtl/lotr_pkg.sv
// lotr_pkg: shared opcode/state types, C2F sizing and a lowest-set-bit helper for the ring controller
package lotr_pkg;
  localparam int C2F_ENTRIESNUM = 4;
  localparam int C2F_MSB = 3;
  localparam int C2F_ENC_MSB = 1;
  localparam int C2F_ID_W = C2F_ENC_MSB + 1;
  typedef enum logic [1:0] {RD = 2'd0, RD_RSP = 2'd1, WR = 2'd2, WR_BCAST = 2'd3} t_opcode;
  typedef enum logic [2:0] {
    FREE, WRITE, WRITE_BCAST, WRITE_BCAST_PRGRS, READ, READ_PRGRS, READ_RDY, ERROR
  } t_state;
  typedef struct packed {
    t_state      state;
    t_opcode     opcode;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  thread;
  } t_entry;
  function automatic logic [C2F_ID_W-1:0] first_set(input logic [C2F_MSB:0] v);
    first_set = '0;
    for (int i = C2F_MSB; i >= 0; i--) if (v[i]) first_set = C2F_ID_W'(i);
  endfunction
endpackage

// File: rtl/rc_c2f_id_fifo.sv
// rc_c2f_id_fifo: issue-order FIFO of entry ids
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/id_i write; pop_i read (only when non-empty);
//        empty_o no ids held; head_o oldest id.
module rc_c2f_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] id_i,
  input  logic         pop_i,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign empty_o = cnt_q == '0;
  assign head_o = mem_q[rd_q];
  always_ff @(posedge clk_i) if (push_i) mem_q[wr_q] <= id_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= push_i ? inc(wr_q) : wr_q;
      rd_q <= pop_i ? inc(rd_q) : rd_q;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
endmodule

// File: rtl/rc_c2f_buffer.sv
// rc_c2f_buffer: core-to-fabric request buffer, issues in arrival order and matches ring returns
// Ports: QClk/RstQnt clock and async active-low reset; CoreReq* core request in, C2fFull no free entry;
//        C2fReq* head request to arbiter, C2fReqGnt grant; RingRsp*/RingBcastRet* ring returns;
//        CoreRsp* read completion to core; C2fError sticky protocol error.
module rc_c2f_buffer
  import lotr_pkg::*;
(
  input  logic                QClk,
  input  logic                RstQnt,
  input  logic                CoreReqValid,
  input  t_opcode             CoreReqOpcode,
  input  logic [31:0]         CoreReqAddress,
  input  logic [31:0]         CoreReqData,
  input  logic [1:0]          CoreReqThread,
  output logic                C2fFull,
  output logic                C2fReqValid,
  output t_opcode             C2fReqOpcode,
  output logic [31:0]         C2fReqAddress,
  output logic [31:0]         C2fReqData,
  output logic [C2F_ID_W-1:0] C2fReqId,
  input  logic                C2fReqGnt,
  input  logic                RingRspValid,
  input  logic [1:0]          RingRspId,
  input  logic [31:0]         RingRspData,
  input  logic                RingBcastRetValid,
  input  logic [1:0]          RingBcastRetId,
  output logic                CoreRspValid,
  output logic [1:0]          CoreRspThread,
  output logic [31:0]         CoreRspData,
  output logic                C2fError
);
  t_entry ent_q [C2F_ENTRIESNUM];
  t_entry ent_d [C2F_ENTRIESNUM];
  logic err_q, err_d;
  logic [C2F_MSB:0] free_v, rdy_v;
  logic [C2F_ID_W-1:0] head_id, alloc_id, dlv_id;
  logic empty, alloc_ok, pop, rsp_ok, bc_ok;
  for (genvar i = 0; i < C2F_ENTRIESNUM; i++) begin : g_v
    assign free_v[i] = ent_q[i].state == FREE;
    assign rdy_v[i] = ent_q[i].state == READ_RDY;
  end
  assign alloc_id = first_set(free_v);
  assign dlv_id = first_set(rdy_v);
  assign C2fFull = ~|free_v;
  assign alloc_ok = CoreReqValid && !C2fFull && CoreReqOpcode != RD_RSP;
  assign pop = C2fReqGnt && !empty;
  assign rsp_ok = RingRspValid && ent_q[RingRspId].state == READ_PRGRS;
  assign bc_ok = RingBcastRetValid && ent_q[RingBcastRetId].state == WRITE_BCAST_PRGRS;
  assign err_d = err_q || (CoreReqValid && (C2fFull || CoreReqOpcode == RD_RSP))
               || (RingRspValid && !rsp_ok) || (RingBcastRetValid && !bc_ok);
  rc_c2f_id_fifo #(.DEPTH(C2F_ENTRIESNUM), .W(C2F_ID_W)) u_fifo (
    .clk_i(QClk), .rst_ni(RstQnt), .push_i(alloc_ok), .id_i(alloc_id),
    .pop_i(pop), .empty_o(empty), .head_o(head_id)
  );
  // Every event touches a distinct entry (each requires a different pre-edge state), so all apply together.
  always_comb begin
    ent_d = ent_q;
    if (pop)
      ent_d[head_id].state = ent_q[head_id].state == WRITE ? FREE :
                             ent_q[head_id].state == READ ? READ_PRGRS : WRITE_BCAST_PRGRS;
    if (alloc_ok)
      ent_d[alloc_id] = '{state: CoreReqOpcode == RD ? READ : CoreReqOpcode == WR ? WRITE : WRITE_BCAST,
                          opcode: CoreReqOpcode, addr: CoreReqAddress, data: CoreReqData,
                          thread: CoreReqThread};
    if (rsp_ok) begin
      ent_d[RingRspId].state = READ_RDY;
      ent_d[RingRspId].data = RingRspData;
    end
    if (bc_ok) ent_d[RingBcastRetId].state = FREE;
    if (|rdy_v) ent_d[dlv_id].state = FREE;
  end
  always_ff @(posedge QClk or negedge RstQnt)
    if (!RstQnt) begin
      ent_q <= '{default: '0};
      err_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      err_q <= err_d;
    end
  assign C2fReqValid = !empty;
  assign C2fReqOpcode = C2fReqValid ? ent_q[head_id].opcode : RD;
  assign C2fReqAddress = C2fReqValid ? ent_q[head_id].addr : '0;
  assign C2fReqData = C2fReqValid ? ent_q[head_id].data : '0;
  assign C2fReqId = C2fReqValid ? head_id : '0;
  assign CoreRspValid = |rdy_v;
  assign CoreRspThread = CoreRspValid ? ent_q[dlv_id].thread : '0;
  assign CoreRspData = CoreRspValid ? ent_q[dlv_id].data : '0;
  assign C2fError = err_q;
endmodule

// File: tb/tb_rc_c2f_buffer.sv
// tb_rc_c2f_buffer: directed scoreboard bench for rc_c2f_buffer
module tb_rc_c2f_buffer;
  import lotr_pkg::*;
  logic QClk = 1'b0, RstQnt = 1'b0;
  logic CoreReqValid = 1'b0;
  t_opcode CoreReqOpcode = RD;
  logic [31:0] CoreReqAddress = '0, CoreReqData = '0;
  logic [1:0] CoreReqThread = '0;
  logic C2fFull, C2fReqValid, CoreRspValid, C2fError;
  t_opcode C2fReqOpcode;
  logic [31:0] C2fReqAddress, C2fReqData, CoreRspData;
  logic [1:0] C2fReqId, CoreRspThread;
  logic C2fReqGnt = 1'b0, RingRspValid = 1'b0, RingBcastRetValid = 1'b0;
  logic [1:0] RingRspId = '0, RingBcastRetId = '0;
  logic [31:0] RingRspData = '0;
  int total = 0, npass = 0;
  typedef struct {logic [1:0] id; t_opcode op; logic [31:0] addr; logic [31:0] data;} iss_t;
  typedef struct {logic [1:0] thr; logic [31:0] data;} rsp_t;
  iss_t iq[$];
  rsp_t rq[$];

  rc_c2f_buffer dut (
    .QClk(QClk), .RstQnt(RstQnt), .CoreReqValid(CoreReqValid), .CoreReqOpcode(CoreReqOpcode),
    .CoreReqAddress(CoreReqAddress), .CoreReqData(CoreReqData), .CoreReqThread(CoreReqThread),
    .C2fFull(C2fFull), .C2fReqValid(C2fReqValid), .C2fReqOpcode(C2fReqOpcode),
    .C2fReqAddress(C2fReqAddress), .C2fReqData(C2fReqData), .C2fReqId(C2fReqId),
    .C2fReqGnt(C2fReqGnt), .RingRspValid(RingRspValid), .RingRspId(RingRspId),
    .RingRspData(RingRspData), .RingBcastRetValid(RingBcastRetValid), .RingBcastRetId(RingBcastRetId),
    .CoreRspValid(CoreRspValid), .CoreRspThread(CoreRspThread), .CoreRspData(CoreRspData),
    .C2fError(C2fError)
  );

  always #5 QClk = ~QClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge QClk);
    #1;
  endtask

  task automatic idle();
    CoreReqValid = 1'b0;
    C2fReqGnt = 1'b0;
    RingRspValid = 1'b0;
    RingBcastRetValid = 1'b0;
  endtask

  task automatic alloc(input logic [1:0] id, input t_opcode op, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] t);
    CoreReqValid = 1'b1;
    CoreReqOpcode = op;
    CoreReqAddress = a;
    CoreReqData = d;
    CoreReqThread = t;
    iq.push_back('{id, op, a, d});
  endtask

  task automatic head_chk();
    if (iq.size() == 0) chk("req_valid_idle", 32'(C2fReqValid), 0);
    else begin
      chk("req_valid", 32'(C2fReqValid), 1);
      chk("req_id", 32'(C2fReqId), 32'(iq[0].id));
      chk("req_op", 32'(C2fReqOpcode), 32'(iq[0].op));
      chk("req_addr", C2fReqAddress, iq[0].addr);
      chk("req_data", C2fReqData, iq[0].data);
    end
  endtask

  task automatic gnt_on();
    head_chk();
    C2fReqGnt = 1'b1;
    if (iq.size() != 0) void'(iq.pop_front());
  endtask

  task automatic ring_rsp(input logic [1:0] id, input logic [31:0] d, input logic [1:0] thr);
    RingRspValid = 1'b1;
    RingRspId = id;
    RingRspData = d;
    rq.push_back('{thr, d});
  endtask

  task automatic rsp_chk();
    if (rq.size() == 0) chk("rsp_valid_idle", 32'(CoreRspValid), 0);
    else begin
      chk("rsp_valid", 32'(CoreRspValid), 1);
      chk("rsp_thread", 32'(CoreRspThread), 32'(rq[0].thr));
      chk("rsp_data", CoreRspData, rq[0].data);
      void'(rq.pop_front());
    end
  endtask

  task automatic st_chk(input string tag, input int i, input t_state s);
    chk(tag, 32'(dut.ent_q[i].state), 32'(s));
  endtask

  initial begin
    #2;
    chk("rst_full", 32'(C2fFull), 0);
    chk("rst_req_valid", 32'(C2fReqValid), 0);
    chk("rst_rsp_valid", 32'(CoreRspValid), 0);
    chk("rst_err", 32'(C2fError), 0);
    #10 RstQnt = 1'b1;
    tick();
    // basic read
    alloc(0, RD, 32'h0240_0010, 32'h0, 2);
    chk("basic_full", 32'(C2fFull), 0);
    tick(); idle();
    gnt_on(); tick(); idle();
    st_chk("basic_prgrs", 0, READ_PRGRS);
    head_chk();
    ring_rsp(0, 32'hDEAD_BEEF, 2);
    chk("basic_rsp_lat", 32'(CoreRspValid), 0);
    tick(); idle();
    rsp_chk();
    tick();
    rsp_chk();
    st_chk("basic_free", 0, FREE);
    chk("basic_err", 32'(C2fError), 0);
    // issue ordering and freed-entry reuse
    alloc(0, WR, 32'h1000, 32'hA0, 0); tick();
    alloc(1, WR, 32'h1001, 32'hA1, 1); tick();
    alloc(2, WR, 32'h1002, 32'hA2, 2); tick(); idle();
    gnt_on(); alloc(3, WR, 32'h1003, 32'hA3, 3); tick(); idle();
    alloc(0, WR, 32'h1004, 32'hA4, 0); tick(); idle();
    for (int i = 0; i < 4; i++) begin gnt_on(); tick(); idle(); end
    head_chk();
    // broadcast
    alloc(0, WR_BCAST, 32'hFF00_0000, 32'hCAFE_0001, 1); tick(); idle();
    gnt_on(); tick(); idle();
    st_chk("bc_prgrs", 0, WRITE_BCAST_PRGRS);
    repeat (3) tick();
    st_chk("bc_held", 0, WRITE_BCAST_PRGRS);
    head_chk();
    RingBcastRetValid = 1'b1; RingBcastRetId = 0;
    tick(); idle();
    st_chk("bc_free", 0, FREE);
    chk("bc_err", 32'(C2fError), 0);
    // simultaneous grant, allocate, response
    alloc(0, RD, 32'h2000, 32'h0, 3); tick(); idle();
    gnt_on(); tick(); idle();
    alloc(1, WR, 32'h2001, 32'h55, 0); tick(); idle();
    gnt_on(); alloc(2, RD, 32'h2002, 32'h0, 1); ring_rsp(0, 32'h1234_5678, 3);
    tick(); idle();
    st_chk("sim_wr_free", 1, FREE);
    st_chk("sim_rd_alloc", 2, READ);
    st_chk("sim_rsp_rdy", 0, READ_RDY);
    rsp_chk();
    gnt_on(); tick(); idle();
    st_chk("sim_dlv_free", 0, FREE);
    st_chk("sim_rd2_prgrs", 2, READ_PRGRS);
    ring_rsp(2, 32'h0BAD_F00D, 1); tick(); idle();
    rsp_chk();
    tick();
    rsp_chk();
    chk("sim_err", 32'(C2fError), 0);
    // fill to full, overflow request dropped
    for (int i = 0; i < 4; i++) begin
      chk("fill_not_full", 32'(C2fFull), 0);
      alloc(2'(i), WR, 32'h3000 + i, 32'h1111_1111 * i, 2'(i));
      tick();
    end
    idle();
    chk("fill_full", 32'(C2fFull), 1);
    CoreReqValid = 1'b1; CoreReqOpcode = RD; CoreReqAddress = 32'h3FFF;
    tick(); idle();
    chk("fill_err", 32'(C2fError), 1);
    chk("fill_still_full", 32'(C2fFull), 1);
    gnt_on(); tick(); idle();
    chk("fill_freed", 32'(C2fFull), 0);
    for (int i = 0; i < 3; i++) begin gnt_on(); tick(); idle(); end
    head_chk();
    // async reset with read in flight, then stray return
    alloc(0, RD, 32'h4000, 32'h0, 2); tick(); idle();
    gnt_on(); tick(); idle();
    st_chk("rst_mid_prgrs", 0, READ_PRGRS);
    #2 RstQnt = 1'b0;
    #1;
    chk("arst_full", 32'(C2fFull), 0);
    chk("arst_req_valid", 32'(C2fReqValid), 0);
    chk("arst_rsp_valid", 32'(CoreRspValid), 0);
    chk("arst_err", 32'(C2fError), 0);
    st_chk("arst_free", 0, FREE);
    #1 RstQnt = 1'b1;
    tick();
    RingRspValid = 1'b1; RingRspId = 0; RingRspData = 32'h7777_7777;
    tick(); idle();
    chk("stray_err", 32'(C2fError), 1);
    chk("stray_no_rsp", 32'(CoreRspValid), 0);
    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end
endmodule
